// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks in-flight
// destinations, registers EX operand forward codes and sequences stalls/bubbles.
`ifndef ForwardCodePath
`define ForwardCodePath [1:0]
`define NO_FORWARD      2'b00
`define EXMEM_FORWARD   2'b01
`define MEMWB_FORWARD   2'b10
`endif

module hazard_forward_ctrl #(
  parameter int REG_W         = 5,
  parameter int MULTI_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  input  logic [REG_W-1:0]      idRs,
  input  logic [REG_W-1:0]      idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  idDstValid,
  input  logic [REG_W-1:0]      idDst,
  input  logic                  idIsLoad,
  input  logic                  idMulti,
  input  logic                  flush,
  output logic `ForwardCodePath forwardCodeA,
  output logic `ForwardCodePath forwardCodeB,
  output logic                  stallFront,
  output logic                  bubbleIdEx,
  output logic                  holdIdEx,
  output logic                  bubbleExMem
);

  typedef enum logic {RUN, MULTI_WAIT} stateT;

  stateT            stateReg, stateNext;
  logic [3:0]       cntReg, cntNext;

  logic             idexValidReg, idexValidNext;
  logic [REG_W-1:0] idexDstReg, idexDstNext;
  logic             idexIsLoadReg, idexIsLoadNext;
  // The register file is write-before-read, so nothing downstream of EX/MEM
  // ever needs a code; the MEM/WB entry therefore has no observable effect.
  logic             exmemValidReg, exmemValidNext;
  logic [REG_W-1:0] exmemDstReg, exmemDstNext;

  logic [1:0][1:0]       codeReg, codeNext, codeCalc;
  logic [1:0][REG_W-1:0] src;
  logic [1:0]            srcUses;
  logic                  luHaz;

  assign src     = {idRt, idRs};
  assign srcUses = {idUsesRt, idUsesRs};

  // Youngest producer wins: ID/EX is checked before EX/MEM.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
      assign codeCalc[gi] =
        (!srcUses[gi] || src[gi] == '0)               ? `NO_FORWARD    :
        (idexValidReg  && idexDstReg  == src[gi])     ? `EXMEM_FORWARD :
        (exmemValidReg && exmemDstReg == src[gi])     ? `MEMWB_FORWARD :
                                                        `NO_FORWARD;
    end
  endgenerate

  assign luHaz = (stateReg == RUN) && idValid && !flush && idexValidReg && idexIsLoadReg &&
                 ((idUsesRs && idRs == idexDstReg) || (idUsesRt && idRt == idexDstReg));

  assign forwardCodeA = codeReg[0];
  assign forwardCodeB = codeReg[1];

  always_comb begin
    stateNext      = stateReg;
    cntNext        = cntReg;
    idexValidNext  = idexValidReg;
    idexDstNext    = idexDstReg;
    idexIsLoadNext = idexIsLoadReg;
    exmemValidNext = exmemValidReg;
    exmemDstNext   = exmemDstReg;
    codeNext       = codeReg;
    stallFront     = 1'b0;
    bubbleIdEx     = 1'b0;
    holdIdEx       = 1'b0;
    bubbleExMem    = 1'b0;

    case (stateReg)
      RUN: begin
        exmemValidNext = idexValidReg;
        exmemDstNext   = idexDstReg;
        if (flush) begin
          bubbleIdEx    = 1'b1;
          idexValidNext = 1'b0;
          codeNext      = {`NO_FORWARD, `NO_FORWARD};
        end else if (luHaz) begin
          stallFront    = 1'b1;
          bubbleIdEx    = 1'b1;
          idexValidNext = 1'b0;
          codeNext      = {`NO_FORWARD, `NO_FORWARD};
        end else begin
          idexValidNext  = idValid && idDstValid && (idDst != '0);
          idexDstNext    = idDst;
          idexIsLoadNext = idIsLoad;
          codeNext       = codeCalc;
          if (idValid && idMulti) begin
            stateNext = MULTI_WAIT;
            cntNext   = 4'(MULTI_LATENCY - 1);
          end
        end
      end
      MULTI_WAIT: begin
        // Multi-cycle unit already latched its operands, so codes just hold.
        stallFront     = 1'b1;
        holdIdEx       = 1'b1;
        bubbleExMem    = 1'b1;
        exmemValidNext = 1'b0;
        cntNext        = cntReg - 4'd1;
        if (cntReg == 4'd1) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg      <= RUN;
      cntReg        <= 4'd0;
      idexValidReg  <= 1'b0;
      idexDstReg    <= '0;
      idexIsLoadReg <= 1'b0;
      exmemValidReg <= 1'b0;
      exmemDstReg   <= '0;
      codeReg       <= {`NO_FORWARD, `NO_FORWARD};
    end else begin
      stateReg      <= stateNext;
      cntReg        <= cntNext;
      idexValidReg  <= idexValidNext;
      idexDstReg    <= idexDstNext;
      idexIsLoadReg <= idexIsLoadNext;
      exmemValidReg <= exmemValidNext;
      exmemDstReg   <= exmemDstNext;
      codeReg       <= codeNext;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed vector table, a
// mid-wait reset sequence, then random stimulus against a pipeline model.
`ifndef ForwardCodePath
`define ForwardCodePath [1:0]
`define NO_FORWARD      2'b00
`define EXMEM_FORWARD   2'b01
`define MEMWB_FORWARD   2'b10
`endif

module tb_hazard_forward_ctrl;
  localparam int L = 4;
  localparam logic [1:0] N = `NO_FORWARD;
  localparam logic [1:0] E = `EXMEM_FORWARD;
  localparam logic [1:0] M = `MEMWB_FORWARD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idValid, idUsesRs, idUsesRt, idDstValid, idIsLoad, idMulti, flush;
  logic [4:0] idRs, idRt, idDst;
  logic [1:0] forwardCodeA, forwardCodeB;
  logic stallFront, bubbleIdEx, holdIdEx, bubbleExMem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_W(5), .MULTI_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idDstValid(idDstValid), .idDst(idDst),
    .idIsLoad(idIsLoad), .idMulti(idMulti), .flush(flush),
    .forwardCodeA(forwardCodeA), .forwardCodeB(forwardCodeB), .stallFront(stallFront),
    .bubbleIdEx(bubbleIdEx), .holdIdEx(holdIdEx), .bubbleExMem(bubbleExMem)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       dv;
    logic [4:0] dst;
    logic       ld;
    logic       mul;
    logic       fl;
    logic [3:0] ctrl;   // {stallFront, bubbleIdEx, holdIdEx, bubbleExMem}
    logic [1:0] ca;
    logic [1:0] cb;
  } vecT;

  function automatic vecT mk(logic v, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                             logic dv, logic [4:0] dst, logic ld, logic mul, logic fl,
                             logic [3:0] ctrl, logic [1:0] ca, logic [1:0] cb);
    vecT r;
    r.v = v; r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt; r.dv = dv; r.dst = dst;
    r.ld = ld; r.mul = mul; r.fl = fl; r.ctrl = ctrl; r.ca = ca; r.cb = cb;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vecT t);
    idValid = t.v; idRs = t.rs; idUsesRs = t.urs; idRt = t.rt; idUsesRt = t.urt;
    idDstValid = t.dv; idDst = t.dst; idIsLoad = t.ld; idMulti = t.mul; flush = t.fl;
  endtask

  task automatic chkCtrl(string tag, logic [3:0] exp);
    chk({tag, " stallFront"},  int'(stallFront),  int'(exp[3]));
    chk({tag, " bubbleIdEx"},  int'(bubbleIdEx),  int'(exp[2]));
    chk({tag, " holdIdEx"},    int'(holdIdEx),    int'(exp[1]));
    chk({tag, " bubbleExMem"}, int'(bubbleExMem), int'(exp[0]));
  endtask

  task automatic chkCodes(string tag, logic [1:0] ea, logic [1:0] eb);
    chk({tag, " forwardCodeA"}, int'(forwardCodeA), int'(ea));
    chk({tag, " forwardCodeB"}, int'(forwardCodeB), int'(eb));
  endtask

  // Pipeline model: slot 0 = instruction in EX, slot 1 = instruction in MEM.
  logic       prodValid [2];
  logic [4:0] prodDst   [2];
  logic       prodLoad  [2];
  int         exRemaining;   // EX cycles still owed by the instruction in EX
  logic [1:0] expA, expB;

  function automatic logic [1:0] modelCode(logic [4:0] s, logic used);
    if (!used || s == 0) return N;
    for (int k = 0; k < 2; k++)
      if (prodValid[k] && prodDst[k] == s) return (k == 0) ? E : M;
    return N;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      prodValid[k] = 1'b0; prodDst[k] = '0; prodLoad[k] = 1'b0;
    end
    exRemaining = 1;
    expA = N; expB = N;
  endtask

  task automatic randCycle(int n);
    vecT t;
    logic busy, haz;
    logic [1:0] nA, nB;
    t = mk($urandom_range(7) != 0, 5'($urandom_range(5)), 1'($urandom), 5'($urandom_range(5)),
           1'($urandom), 1'($urandom), 5'($urandom_range(5)), $urandom_range(3) == 0,
           $urandom_range(9) == 0, $urandom_range(11) == 0, 4'b0, N, N);
    drive(t);
    busy = exRemaining > 1;
    haz  = !busy && t.v && !t.fl && prodValid[0] && prodLoad[0] &&
           ((t.urs && t.rs == prodDst[0]) || (t.urt && t.rt == prodDst[0]));
    nA = modelCode(t.rs, t.urs);
    nB = modelCode(t.rt, t.urt);
    #3;
    chkCtrl("rand", {busy || haz, !busy && (t.fl || haz), busy, busy});
    @(posedge clk); #1;
    if (busy) begin
      exRemaining--;
      prodValid[1] = 1'b0;
    end else begin
      prodValid[1] = prodValid[0]; prodDst[1] = prodDst[0]; prodLoad[1] = prodLoad[0];
      if (t.fl || haz) begin
        prodValid[0] = 1'b0;
        exRemaining  = 1;
        expA = N; expB = N;
      end else begin
        prodValid[0] = t.v && t.dv && t.dst != 0;
        prodDst[0]   = t.dst;
        prodLoad[0]  = t.ld;
        exRemaining  = (t.v && t.mul) ? L : 1;
        expA = nA; expB = nB;
      end
    end
    chkCodes("rand", expA, expB);
    $display("rand %0d: v=%0b rs=%0d/%0b rt=%0d/%0b dst=%0d/%0b ld=%0b mul=%0b fl=%0b -> codes %0d %0d",
             n, t.v, t.rs, t.urs, t.rt, t.urt, t.dst, t.dv, t.ld, t.mul, t.fl, forwardCodeA, forwardCodeB);
  endtask

  vecT vec [24];
  vecT idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, N, N);
    vec[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 4'b0000, N, N);  // add r3
    vec[1]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, E, N);  // reads r3 from ID/EX
    vec[2]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 4'b0000, N, N);  // write r4
    vec[3]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 4'b0000, N, N);  // write r4 again
    vec[4]  = mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 4'b0000, N, E);  // youngest wins
    vec[5]  = mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 4'b0000, N, M);  // only EX/MEM
    vec[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, N, N);  // write r0
    vec[7]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000, N, N);  // reads r0
    vec[8]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 4'b0000, N, N);  // load r5
    vec[9]  = mk(1, 0, 0, 5, 1, 1, 6, 0, 0, 0, 4'b1100, N, N);  // load-use stall
    vec[10] = mk(1, 0, 0, 5, 1, 1, 6, 0, 0, 0, 4'b0000, N, M);  // advances
    vec[11] = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 4'b0000, N, N);  // load r5
    vec[12] = mk(1, 0, 0, 5, 1, 1, 6, 0, 0, 1, 4'b0100, N, N);  // load-use + flush
    vec[13] = idle;
    vec[14] = mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 0, 4'b0000, N, N);  // multi -> r7
    vec[15] = mk(1, 7, 1, 0, 0, 1, 8, 0, 1, 0, 4'b1011, N, N);
    vec[16] = mk(1, 7, 1, 0, 0, 1, 8, 0, 1, 0, 4'b1011, N, N);
    vec[17] = mk(1, 7, 1, 0, 0, 1, 8, 0, 1, 0, 4'b1011, N, N);
    vec[18] = mk(1, 7, 1, 0, 0, 1, 8, 0, 1, 0, 4'b0000, E, N);  // back-to-back multi
    vec[19] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 4'b1011, E, N);  // flush ignored
    vec[20] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1011, E, N);
    vec[21] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1011, E, N);
    vec[22] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, E, N);
    vec[23] = idle;

    drive(idle);
    #1 rst = 1'b0;
    #1;
    chkCtrl("reset", 4'b0000);
    chkCodes("reset", N, N);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      drive(vec[i]);
      #3;
      chkCtrl($sformatf("vec%0d", i), vec[i].ctrl);
      @(posedge clk); #1;
      chkCodes($sformatf("vec%0d", i), vec[i].ca, vec[i].cb);
      $display("vec %0d: ctrl=%b%b%b%b codes %0d %0d", i, stallFront, bubbleIdEx, holdIdEx,
               bubbleExMem, forwardCodeA, forwardCodeB);
    end

    // Reset pulled low in the second MULTI_WAIT cycle.
    drive(mk(1, 0, 0, 0, 0, 1, 9, 0, 1, 0, 4'b0, N, N));
    @(posedge clk); #1;
    drive(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0, N, N));
    #3;
    chkCtrl("mw1", 4'b1011);
    @(posedge clk); #1;
    chkCtrl("mw2", 4'b1011);
    rst = 1'b0;
    #1;
    chkCtrl("midreset", 4'b0000);
    chkCodes("midreset", N, N);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drive(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0, N, N));
    #3;
    chkCtrl("postreset", 4'b0000);
    @(posedge clk); #1;
    chkCodes("postreset", N, N);
    $display("midreset sequence: codes %0d %0d", forwardCodeA, forwardCodeB);

    // Bring DUT and model to a common reset state, then randomize.
    drive(idle);
    rst = 1'b0;
    modelReset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) randCycle(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It tracks the destination register of every instruction in ID/EX, EX/MEM and MEM/WB, and generates the registered `forwardCode` pair consumed by the EX-stage operand forwarding multiplexers. It also sequences pipeline stalls and bubbles for load-use hazards and multi-cycle EX operations. It sits beside the ID stage and drives the hold/bubble controls of PC, IF/ID, ID/EX and EX/MEM.

## Interface
- REG_W, 5: register-number width.
- MULTI_LATENCY, 4: EX-stage occupancy in cycles of a multi-cycle op; legal range 2..15.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- idValid  in  1  ID holds a real instruction.
- idRs, idRt  in  REG_W  source registers of the ID instruction.
- idUsesRs, idUsesRt  in  1  the corresponding source is actually read.
- idDstValid  in  1  ID instruction writes a register.
- idDst  in  REG_W  destination register.
- idIsLoad  in  1  ID instruction is a load.
- idMulti  in  1  ID instruction is a multi-cycle EX op.
- flush  in  1  branch redirect resolved in EX; kills the ID instruction.
- forwardCodeA, forwardCodeB  out  `ForwardCodePath  registered; aligned with ID/EX; values `NO_FORWARD` / `EXMEM_FORWARD` / `MEMWB_FORWARD`.
- stallFront  out  1  hold PC and IF/ID.
- bubbleIdEx  out  1  write NOP into ID/EX.
- holdIdEx  out  1  ID/EX keeps its contents.
- bubbleExMem  out  1  write NOP into EX/MEM.

## Operation
- Tracking entries: idex, exmem and memwb, each holding {valid, dst, isLoad}. An entry is valid only if its instruction writes a nonzero register.
- FSM states:
  - RUN: normal operation.
  - MULTI_WAIT: a multi-cycle op occupies EX.
  - A 4-bit down-counter `cnt` sequences MULTI_WAIT.
- Hazard term `luHaz`: state==RUN, idValid, !flush, idex.valid, idex.isLoad, and (idUsesRs && idRs==idex.dst, or idUsesRt && idRt==idex.dst).
- Forward code for source S (computed in ID, registered into the forwardCode outputs):
  - S==0, or S not used: `NO_FORWARD`.
  - Else if idex.valid && idex.dst==S: `EXMEM_FORWARD`. The youngest producer wins.
  - Else if exmem.valid && exmem.dst==S: `MEMWB_FORWARD`.
  - Else `NO_FORWARD`. The register file is write-before-read, so memwb needs no code.
- RUN, no luHaz, no flush:
  - All control outputs 0.
  - idex ← ID info (invalid if !idValid); exmem ← idex; memwb ← exmem.
  - Codes ← computed values.
  - If idValid && idMulti: go to MULTI_WAIT with cnt ← MULTI_LATENCY−1.
- RUN, flush:
  - bubbleIdEx=1, stallFront=0.
  - idex ← invalid; codes ← `NO_FORWARD`. A concurrent luHaz is suppressed.
- RUN, luHaz:
  - stallFront=1, bubbleIdEx=1.
  - idex ← invalid; exmem ← idex; memwb ← exmem; codes ← `NO_FORWARD`.
  - On the next cycle the load sits in exmem, so the same instruction receives `MEMWB_FORWARD`.
- MULTI_WAIT:
  - stallFront=1, holdIdEx=1, bubbleExMem=1, bubbleIdEx=0.
  - idex and codes hold; exmem ← invalid; memwb ← exmem.
  - cnt decrements each cycle; at the edge where cnt==1, go to RUN.
  - luHaz and flush are ignored in this state.
- The multi-cycle unit latches its forwarded operands in its first EX cycle. Holding the codes during the wait is therefore sufficient.

## Timing
- Reset (asynchronous, rst low):
  - State RUN, cnt 0, all entries invalid.
  - forwardCodeA/B = `NO_FORWARD`; stallFront, bubbleIdEx, holdIdEx, bubbleExMem all 0.
  - Effective immediately, including mid-MULTI_WAIT.
- Control outputs are combinational from state, inputs and entries, and are valid in the same cycle.
- Forward codes have 1-cycle latency: they are computed in ID and take effect when the instruction is in EX.
- Load-use costs exactly 1 bubble cycle.
- A multi-cycle op stays in EX for exactly MULTI_LATENCY cycles: MULTI_LATENCY−1 stall cycles in MULTI_WAIT plus one RUN cycle, after which it advances.
- A multi-cycle op that immediately follows another re-enters MULTI_WAIT on the edge where it enters ID/EX, with no gap cycle.

## Test plan
- Producer add r3 in ID/EX; ID consumer with idRs=3, idUsesRs=1 -> next cycle forwardCodeA=`EXMEM_FORWARD`, forwardCodeB=`NO_FORWARD`, no stall.
- Writes to r4 in both ID/EX and EX/MEM; consumer with idRt=4 -> forwardCodeB=`EXMEM_FORWARD`. With only the EX/MEM write -> `MEMWB_FORWARD`. With a destination of r0 -> `NO_FORWARD`.
- Load r5 in ID/EX; consumer idRt=5 -> stallFront=1 and bubbleIdEx=1 for exactly 1 cycle, then forwardCodeB=`MEMWB_FORWARD` and the instruction advances.
- Same load-use case with flush=1 in the hazard cycle -> stallFront=0, bubbleIdEx=1, codes `NO_FORWARD`.
- MULTI_LATENCY=4, multi op enters ID/EX -> stallFront/holdIdEx/bubbleExMem high for 3 cycles, low on the 4th; back-to-back multi ops -> 3 stall cycles, 1 free cycle, 3 stall cycles.
- rst pulled low in the 2nd MULTI_WAIT cycle -> all outputs immediately at reset values. After release, the first instruction sees `NO_FORWARD` and no stall.
